gemm_tile_controller: RTL

Parametrised tile sequencer for the systolic PE array. It walks an M x K by K x N GEMM as ceil(M/ROWS) x ceil(N/COLS) output tiles. For each tile it generates operand SRAM reads, skewed FIFO push/pop enables, PE compute/flush strobes and output SRAM writes. It sits between the host start/config interface and the SRAM, FIFO and PE-array datapath, and adds edge-tile masking and output back-pressure.

---
 rtl/gemm_tile_controller_pkg.sv | 27 ++
 rtl/gemm_tile_controller_skew_mask.sv | 33 +++
 rtl/gemm_tile_controller.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_tile_controller_pkg.sv
// Shared definitions for the GEMM tile controller.
//   state_t         : controller FSM encoding
//   comp_phase_len  : length of the compute phase for a given inner dimension
//   lane_cnt_width  : width needed to hold a valid-lane count 0..2**lanes_log2
package gemm_tile_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COMP  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The skewed wavefront needs K cycles for the first lane plus
  // (ROWS-1)+(COLS-1) extra cycles for the last diagonal to drain.
  function automatic logic [31:0] comp_phase_len(input logic [31:0] k,
                                                 input int          rows,
                                                 input int          cols);
    return k + 32'(rows) + 32'(cols) - 32'd2;
  endfunction

  function automatic int lane_cnt_width(input int lanes_log2);
    return lanes_log2 + 1;
  endfunction

endpackage

// File: rtl/gemm_tile_controller_skew_mask.sv
// gemm_skew_mask: per-lane pop mask for the skewed operand FIFOs.
// Lane i pops on compute steps i .. i+K-1, provided the lane is valid
// (i < valid_cnt) for the current edge tile.
//   step      : compute-phase step counter
//   k_size    : inner dimension K of the job
//   valid_cnt : number of valid lanes in this tile
//   pop_mask  : one pop enable per lane
module gemm_skew_mask
  import gemm_tile_controller_pkg::*;
#(
  parameter int LANES  = 32,
  parameter int STEP_W = 11,
  parameter int K_W    = 9,
  parameter int CNT_W  = 6
) (
  input  logic [STEP_W-1:0] step,
  input  logic [K_W-1:0]    k_size,
  input  logic [CNT_W-1:0]  valid_cnt,
  output logic [LANES-1:0]  pop_mask
);

  always_comb begin
    pop_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((i < int'(valid_cnt)) &&
          (int'(step) >= i) &&
          (int'(step) < i + int'(k_size))) begin
        pop_mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gemm_tile_controller.sv
// gemm_tile_controller: tile sequencer for the systolic PE array.
// Walks an MxK by KxN GEMM as ceil(M/ROWS) x ceil(N/COLS) output tiles
// (tile_col innermost). Per tile: LOAD (operand SRAM reads, FIFO pushes one
// cycle later), COMP (skewed FIFO pops + MAC enable), FLUSH (one output row
// per cycle, stalled by OUT_READY).
// Ports:
//   CLK, RST (async, active-high)
//   START, M_SIZE, K_SIZE, N_SIZE : job launch and dimensions
//   OUT_READY                      : output sink back-pressure
//   OPND1/2_SRAM_ADDR/RE           : operand SRAM reads
//   OUT_SRAM_ADDR/WE               : result SRAM writes
//   OPND1/2_FIFO_PUSHEs/POPEs      : per-lane operand FIFO strobes
//   ROWEs, COLEs                   : flush row select, valid-column mask
//   COMPUTE, FLUSH, STALL          : PE array control / stall indicator
//   BUSY, FINISHED                 : job status
// Optional: define GEMM_TILE_CTRL_PERF_EN to add PERF_BUSY_CYCLES and
// PERF_STALL_CYCLES saturating 32-bit counters.
module gemm_tile_controller
  import gemm_tile_controller_pkg::*;
#(
  parameter int PE_ARRAY_NUM_ROWS      = 32,
  parameter int PE_ARRAY_NUM_ROWS_LOG2 = 5,
  parameter int PE_ARRAY_NUM_COLS      = 32,
  parameter int PE_ARRAY_NUM_COLS_LOG2 = 5,
  parameter int MAX_M_SIZE_LOG2        = 9,
  parameter int MAX_K_SIZE_LOG2        = 9,
  parameter int MAX_N_SIZE_LOG2        = 9,
  parameter int OPND1_SRAM_AWIDTH      = 10,
  parameter int OPND2_SRAM_AWIDTH      = 10,
  parameter int OUT_SRAM_AWIDTH        = 10
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic [MAX_M_SIZE_LOG2-1:0]   M_SIZE,
  input  logic [MAX_K_SIZE_LOG2-1:0]   K_SIZE,
  input  logic [MAX_N_SIZE_LOG2-1:0]   N_SIZE,
  input  logic                         OUT_READY,
  output logic [OPND1_SRAM_AWIDTH-1:0] OPND1_SRAM_ADDR,
  output logic [OPND2_SRAM_AWIDTH-1:0] OPND2_SRAM_ADDR,
  output logic                         OPND1_SRAM_RE,
  output logic                         OPND2_SRAM_RE,
  output logic [OUT_SRAM_AWIDTH-1:0]   OUT_SRAM_ADDR,
  output logic                         OUT_SRAM_WE,
  output logic [PE_ARRAY_NUM_ROWS-1:0] OPND1_FIFO_PUSHEs,
  output logic [PE_ARRAY_NUM_ROWS-1:0] OPND1_FIFO_POPEs,
  output logic [PE_ARRAY_NUM_COLS-1:0] OPND2_FIFO_PUSHEs,
  output logic [PE_ARRAY_NUM_COLS-1:0] OPND2_FIFO_POPEs,
  output logic [PE_ARRAY_NUM_ROWS-1:0] ROWEs,
  output logic [PE_ARRAY_NUM_COLS-1:0] COLEs,
  output logic                         COMPUTE,
  output logic                         FLUSH,
  output logic                         STALL,
  output logic                         BUSY,
  output logic                         FINISHED
`ifdef GEMM_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]                  PERF_BUSY_CYCLES,
  output logic [31:0]                  PERF_STALL_CYCLES
`endif
);

  localparam int TR_W   = MAX_M_SIZE_LOG2 - PE_ARRAY_NUM_ROWS_LOG2 + 1;
  localparam int TC_W   = MAX_N_SIZE_LOG2 - PE_ARRAY_NUM_COLS_LOG2 + 1;
  localparam int STEP_W = MAX_K_SIZE_LOG2 + 2;
  localparam int VR_W   = lane_cnt_width(PE_ARRAY_NUM_ROWS_LOG2);
  localparam int VC_W   = lane_cnt_width(PE_ARRAY_NUM_COLS_LOG2);

  state_t                       state_q, state_d;
  logic [STEP_W-1:0]            step_q, step_d;
  logic [TR_W-1:0]              tile_row_q, tile_row_d;
  logic [TC_W-1:0]              tile_col_q, tile_col_d;

  logic [MAX_M_SIZE_LOG2-1:0]   m_q;
  logic [MAX_K_SIZE_LOG2-1:0]   k_q;
  logic [MAX_N_SIZE_LOG2-1:0]   n_q;
  logic [TR_W-1:0]              tm_q;
  logic [TC_W-1:0]              tn_q;

  logic [PE_ARRAY_NUM_ROWS-1:0] opnd1_push_p1;
  logic [PE_ARRAY_NUM_COLS-1:0] opnd2_push_p1;

  logic [31:0]                  row_rem, col_rem;
  logic [VR_W-1:0]              vr;
  logic [VC_W-1:0]              vc;
  logic [PE_ARRAY_NUM_ROWS-1:0] row_mask, row_pop;
  logic [PE_ARRAY_NUM_COLS-1:0] col_mask, col_pop;

  logic start_ok, last_load, last_comp, last_flush_row, last_tile_col, last_tile_row;

  // Edge-tile valid lane counts
  assign row_rem = 32'(m_q) - 32'(tile_row_q) * 32'(PE_ARRAY_NUM_ROWS);
  assign col_rem = 32'(n_q) - 32'(tile_col_q) * 32'(PE_ARRAY_NUM_COLS);
  assign vr = (row_rem >= 32'(PE_ARRAY_NUM_ROWS)) ? VR_W'(PE_ARRAY_NUM_ROWS) : VR_W'(row_rem);
  assign vc = (col_rem >= 32'(PE_ARRAY_NUM_COLS)) ? VC_W'(PE_ARRAY_NUM_COLS) : VC_W'(col_rem);

  always_comb begin
    row_mask = '0;
    for (int i = 0; i < PE_ARRAY_NUM_ROWS; i++) row_mask[i] = (i < int'(vr));
  end

  always_comb begin
    col_mask = '0;
    for (int j = 0; j < PE_ARRAY_NUM_COLS; j++) col_mask[j] = (j < int'(vc));
  end

  gemm_skew_mask #(
    .LANES  (PE_ARRAY_NUM_ROWS),
    .STEP_W (STEP_W),
    .K_W    (MAX_K_SIZE_LOG2),
    .CNT_W  (VR_W)
  ) u_row_skew (
    .step      (step_q),
    .k_size    (k_q),
    .valid_cnt (vr),
    .pop_mask  (row_pop)
  );

  gemm_skew_mask #(
    .LANES  (PE_ARRAY_NUM_COLS),
    .STEP_W (STEP_W),
    .K_W    (MAX_K_SIZE_LOG2),
    .CNT_W  (VC_W)
  ) u_col_skew (
    .step      (step_q),
    .k_size    (k_q),
    .valid_cnt (vc),
    .pop_mask  (col_pop)
  );

  assign start_ok       = START && (M_SIZE != '0) && (K_SIZE != '0) && (N_SIZE != '0);
  assign last_load      = (32'(step_q) == 32'(k_q) - 32'd1);
  assign last_comp      = (32'(step_q) ==
                           comp_phase_len(32'(k_q), PE_ARRAY_NUM_ROWS, PE_ARRAY_NUM_COLS) - 32'd1);
  assign last_flush_row = (32'(step_q) == 32'(vr) - 32'd1);
  assign last_tile_col  = (32'(tile_col_q) == 32'(tn_q) - 32'd1);
  assign last_tile_row  = (32'(tile_row_q) == 32'(tm_q) - 32'd1);

  // Job configuration: captured once per accepted START, no reset needed
  always_ff @(posedge CLK) begin
    if ((state_q == ST_IDLE) && START) begin
      m_q  <= M_SIZE;
      k_q  <= K_SIZE;
      n_q  <= N_SIZE;
      tm_q <= TR_W'((32'(M_SIZE) + 32'(PE_ARRAY_NUM_ROWS) - 32'd1) >> PE_ARRAY_NUM_ROWS_LOG2);
      tn_q <= TC_W'((32'(N_SIZE) + 32'(PE_ARRAY_NUM_COLS) - 32'd1) >> PE_ARRAY_NUM_COLS_LOG2);
    end
  end

  // FSM state and sequencing counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      tile_row_q <= '0;
      tile_col_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tile_row_q <= tile_row_d;
      tile_col_q <= tile_col_d;
    end
  end

  // p1: FIFO pushes trail the SRAM read by its one-cycle latency
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      opnd1_push_p1 <= '0;
      opnd2_push_p1 <= '0;
    end else begin
      opnd1_push_p1 <= (state_q == ST_LOAD) ? row_mask : '0;
      opnd2_push_p1 <= (state_q == ST_LOAD) ? col_mask : '0;
    end
  end

  assign OPND1_FIFO_PUSHEs = opnd1_push_p1;
  assign OPND2_FIFO_PUSHEs = opnd2_push_p1;

  always_comb begin
    state_d         = state_q;
    step_d          = step_q;
    tile_row_d      = tile_row_q;
    tile_col_d      = tile_col_q;
    OPND1_SRAM_ADDR = '0;
    OPND2_SRAM_ADDR = '0;
    OPND1_SRAM_RE   = 1'b0;
    OPND2_SRAM_RE   = 1'b0;
    OUT_SRAM_ADDR   = '0;
    OUT_SRAM_WE     = 1'b0;
    OPND1_FIFO_POPEs = '0;
    OPND2_FIFO_POPEs = '0;
    ROWEs           = '0;
    COLEs           = '0;
    COMPUTE         = 1'b0;
    FLUSH           = 1'b0;
    STALL           = 1'b0;
    BUSY            = (state_q != ST_IDLE);
    FINISHED        = (state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          step_d     = '0;
          tile_row_d = '0;
          tile_col_d = '0;
          state_d    = start_ok ? ST_LOAD : ST_DONE;
        end
      end

      ST_LOAD: begin
        OPND1_SRAM_ADDR = OPND1_SRAM_AWIDTH'(32'(tile_row_q) * 32'(k_q) + 32'(step_q));
        OPND2_SRAM_ADDR = OPND2_SRAM_AWIDTH'(32'(tile_col_q) * 32'(k_q) + 32'(step_q));
        OPND1_SRAM_RE   = 1'b1;
        OPND2_SRAM_RE   = 1'b1;
        if (last_load) begin
          step_d  = '0;
          state_d = ST_COMP;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      ST_COMP: begin
        COMPUTE          = 1'b1;
        OPND1_FIFO_POPEs = row_pop;
        OPND2_FIFO_POPEs = col_pop;
        if (last_comp) begin
          step_d  = '0;
          state_d = ST_FLUSH;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      ST_FLUSH: begin
        // Address and column mask stay presented while stalled so the
        // sink sees a stable row once it becomes ready.
        OUT_SRAM_ADDR = OUT_SRAM_AWIDTH'((32'(tile_row_q) * 32'(PE_ARRAY_NUM_ROWS) + 32'(step_q))
                                         * 32'(tn_q) + 32'(tile_col_q));
        COLEs = col_mask;
        if (OUT_READY) begin
          FLUSH       = 1'b1;
          OUT_SRAM_WE = 1'b1;
          ROWEs       = PE_ARRAY_NUM_ROWS'(1) << step_q;
          if (last_flush_row) begin
            step_d = '0;
            if (last_tile_col) begin
              tile_col_d = '0;
              if (last_tile_row) begin
                state_d = ST_DONE;
              end else begin
                tile_row_d = tile_row_q + TR_W'(1);
                state_d    = ST_LOAD;
              end
            end else begin
              tile_col_d = tile_col_q + TC_W'(1);
              state_d    = ST_LOAD;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else begin
          STALL = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef GEMM_TILE_CTRL_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PERF_BUSY_CYCLES  <= '0;
      PERF_STALL_CYCLES <= '0;
    end else if ((state_q == ST_IDLE) && START) begin
      PERF_BUSY_CYCLES  <= '0;
      PERF_STALL_CYCLES <= '0;
    end else begin
      if (BUSY && (PERF_BUSY_CYCLES != 32'hFFFF_FFFF))
        PERF_BUSY_CYCLES <= PERF_BUSY_CYCLES + 32'd1;
      if (STALL && (PERF_STALL_CYCLES != 32'hFFFF_FFFF))
        PERF_STALL_CYCLES <= PERF_STALL_CYCLES + 32'd1;
    end
  end
`endif

endmodule
